conv1d_obi_reader: RTL

- OBI read master that fetches a contiguous block of 32-bit words from system memory and streams them, in order, to the conv1d datapath over a valid/ready interface.
- Sits directly upstream of the conv1d compute core and drives the conv1d OBI master port.
- Uses the conv1d_obi_pkg obi_req_t/obi_resp_t types.
- An internal response FIFO plus credit-limited issue ensure no response is ever dropped under downstream backpressure.

---
 rtl/conv1d_obi_reader.sv | 261 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/conv1d_obi_reader.sv
// -----------------------------------------------------------------------------
// conv1d_obi_pkg / conv1d_obi_reader
//
// OBI read master feeding the conv1d compute core. It fetches `len_i`
// consecutive 32-bit words starting at `base_addr_i` and streams them, in
// order, over a valid/ready interface. Read responses land in a small FIFO.
// A new request is only issued while (outstanding + buffered) words are below
// FIFO_DEPTH, so a stalled consumer can never cause a response to be dropped.
//
// Ports
//   clk_i        : clock, all state on the rising edge
//   rst_ni       : asynchronous active-low reset
//   start_i      : launch a transfer (sampled only while idle)
//   base_addr_i  : byte address of the first word, bits [1:0] ignored
//   len_i        : number of words to fetch (0 completes immediately)
//   busy_o       : high from the accepted start until completion
//   done_o       : single-cycle completion pulse
//   obi_req_o    : OBI request (req, we, be, addr, wdata)
//   obi_resp_i   : OBI response (gnt, rvalid, rdata)
//   data_o       : FIFO head word (0 when the FIFO is empty)
//   valid_o      : data_o valid
//   ready_i      : consumer accepts data_o
// -----------------------------------------------------------------------------

package conv1d_obi_pkg;

    typedef struct packed {
        logic        req;
        logic        we;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
    } obi_req_t;

    typedef struct packed {
        logic        gnt;
        logic        rvalid;
        logic [31:0] rdata;
    } obi_resp_t;

endpackage

module conv1d_obi_reader
    import conv1d_obi_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned LEN_W      = 16
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             start_i,
    input  logic [31:0]      base_addr_i,
    input  logic [LEN_W-1:0] len_i,
    output logic             busy_o,
    output logic             done_o,
    output obi_req_t         obi_req_o,
    input  obi_resp_t        obi_resp_i,
    output logic [31:0]      data_o,
    output logic             valid_o,
    input  logic             ready_i
);

    localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    // Counters must be able to hold FIFO_DEPTH itself.
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [CNT_W:0] DEPTH_C = FIFO_DEPTH[CNT_W:0];

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2
    } state_e;

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    state_e           state_q;
    logic             req_q;
    logic [31:0]      addr_q;
    logic             busy_q;
    logic             done_q;
    logic [29:0]      base_q;
    logic [LEN_W-1:0] len_q;

    logic [LEN_W-1:0] issued_q,   issued_d;
    logic [LEN_W-1:0] received_q, received_d;
    logic [CNT_W-1:0] outst_q,    outst_d;
    logic [CNT_W-1:0] count_q,    count_d;
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [31:0]      mem_q [FIFO_DEPTH];

    logic             grant;
    logic             resp_acc;
    logic             push;
    logic             pop;
    logic             credit_ok;
    logic [CNT_W:0]   credit_sum;
    logic [31:0]      next_addr;

    // The two low address bits are deliberately discarded.
    logic             unused_addr_lsb;
    assign unused_addr_lsb = ^base_addr_i[1:0];

    // -------------------------------------------------------------------------
    // Next-state counters and issue credit
    // -------------------------------------------------------------------------
    always_comb begin
        grant    = req_q & obi_resp_i.gnt;
        // A response without an outstanding request is a protocol error and
        // is dropped rather than corrupting the counters.
        resp_acc = obi_resp_i.rvalid && (state_q != IDLE) && (outst_q != '0);
        push     = resp_acc;
        pop      = valid_o & ready_i;

        issued_d   = grant    ? issued_q   + LEN_W'(1) : issued_q;
        received_d = resp_acc ? received_q + LEN_W'(1) : received_q;

        case ({grant, resp_acc})
            2'b10:   outst_d = outst_q + CNT_W'(1);
            2'b01:   outst_d = outst_q - CNT_W'(1);
            default: outst_d = outst_q;
        endcase

        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase

        // Credit is judged on the post-edge occupancy so that back-to-back
        // requests are possible while the FIFO keeps draining.
        credit_sum = {1'b0, outst_d} + {1'b0, count_d};
        credit_ok  = credit_sum < DEPTH_C;

        // Word address arithmetic wraps naturally at 2^32.
        next_addr  = {base_q, 2'b00} + (32'(issued_d) << 2);
    end

    // -------------------------------------------------------------------------
    // Control FSM with registered request and status outputs
    // -------------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            req_q   <= 1'b0;
            addr_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            base_q  <= '0;
            len_q   <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start_i) begin
                        base_q <= base_addr_i[31:2];
                        len_q  <= len_i;
                        if (len_i != '0) begin
                            // FIFO is empty and nothing is outstanding here,
                            // so the first request needs no credit check.
                            state_q <= FETCH;
                            busy_q  <= 1'b1;
                            req_q   <= 1'b1;
                            addr_q  <= {base_addr_i[31:2], 2'b00};
                        end else begin
                            done_q  <= 1'b1;
                        end
                    end
                end

                FETCH: begin
                    if (req_q && !obi_resp_i.gnt) begin
                        // Pending request is held unchanged until granted.
                        req_q  <= 1'b1;
                    end else if (issued_d == len_q) begin
                        req_q   <= 1'b0;
                        state_q <= DRAIN;
                    end else begin
                        req_q  <= credit_ok;
                        addr_q <= next_addr;
                    end
                end

                DRAIN: begin
                    req_q <= 1'b0;
                    if ((received_d == len_q) && (outst_d == '0) && (count_d == '0)) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end

                default: begin
                    state_q <= IDLE;
                    req_q   <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Transfer counters and FIFO pointers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            issued_q   <= '0;
            received_q <= '0;
            outst_q    <= '0;
            count_q    <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
        end else begin
            if ((state_q == IDLE) && start_i) begin
                issued_q   <= '0;
                received_q <= '0;
                outst_q    <= '0;
            end else begin
                issued_q   <= issued_d;
                received_q <= received_d;
                outst_q    <= outst_d;
            end
            count_q <= count_d;
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
        end
    end

    // FIFO storage is data only; occupancy alone decides validity.
    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_q[wr_ptr_q] <= obi_resp_i.rdata;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign busy_o          = busy_q;
    assign done_o          = done_q;
    assign valid_o         = (count_q != '0);
    assign data_o          = valid_o ? mem_q[rd_ptr_q] : 32'h0;

    assign obi_req_o.req   = req_q;
    assign obi_req_o.we    = 1'b0;
    assign obi_req_o.be    = req_q ? 4'hF : 4'h0;
    assign obi_req_o.addr  = addr_q;
    assign obi_req_o.wdata = 32'h0;

    // A response must always match an earlier grant.
    rvalid_needs_outstanding: assert property (
        @(posedge clk_i) disable iff (!rst_ni)
        obi_resp_i.rvalid |-> (outst_q != '0)
    );

endmodule
